// File: rtl/dekatron_step_driver.sv
// Sequences STEP / SET / CLEAR / DEC_TO_ZERO commands into Request pulses for a 3-dekatron counter.
// Latency: first Request the cycle after Start; >=3 cycles per step plus counter busy time; Start ignored while Busy.
module dekatron_step_driver #(
  parameter int WIDTH     = 12,
  parameter int CNT_WIDTH = 8,
  parameter int TIMEOUT   = 1023
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 Start,
  input  logic [1:0]           Op,
  input  logic                 Dir,
  input  logic [CNT_WIDTH-1:0] Count,
  input  logic [WIDTH-1:0]     LoadValue,
  input  logic                 CntReady,
  input  logic                 CntZero,
  output logic                 Request,
  output logic                 Dec,
  output logic                 Set,
  output logic                 SetZero,
  output logic [WIDTH-1:0]     In,
  output logic                 Busy,
  output logic                 Done,
  output logic                 Err,
  output logic [CNT_WIDTH-1:0] StepsDone
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [1:0] OP_STEP  = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_DTZ   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_SETTLE,
    S_WAIT,
    S_FINISH,
    S_FAULT
  } state_t;

  state_t               state;
  logic [1:0]           op_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic [TW-1:0]        tcnt;

  logic [CNT_WIDTH-1:0] steps_nxt;
  logic                 last_req;
  logic                 skip_cmd;

  // Decide whether the request just acknowledged is the final one of the command.
  always_comb begin
    steps_nxt = StepsDone + 1'b1;
    last_req  = 1'b1;
    case (op_q)
      OP_STEP: last_req = !(steps_nxt < count_q);
      OP_DTZ:  last_req = CntZero || (steps_nxt == count_q);
      default: last_req = 1'b1;
    endcase
  end

  assign skip_cmd = (((Op == OP_STEP) || (Op == OP_DTZ)) && (Count == '0)) ||
                    ((Op == OP_DTZ) && CntZero);

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state     <= S_IDLE;
      op_q      <= OP_STEP;
      count_q   <= '0;
      tcnt      <= '0;
      Request   <= 1'b0;
      Dec       <= 1'b0;
      Set       <= 1'b0;
      SetZero   <= 1'b0;
      In        <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Err       <= 1'b0;
      StepsDone <= '0;
    end else begin
      Request <= 1'b0;
      Done    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            op_q      <= Op;
            count_q   <= Count;
            StepsDone <= '0;
            Err       <= 1'b0;
            Busy      <= 1'b1;
            if (skip_cmd) begin
              state <= S_FINISH;
              Done  <= 1'b1;
            end else begin
              state   <= S_ISSUE;
              Request <= 1'b1;
              Dec     <= ((Op == OP_STEP) && Dir) || (Op == OP_DTZ);
              Set     <= (Op == OP_SET);
              SetZero <= (Op == OP_CLEAR);
              In      <= LoadValue;
            end
          end
        end
        S_ISSUE: begin
          state <= S_SETTLE;
        end
        // One dead cycle keeps Request low between pulses so the counter sees a clean edge.
        S_SETTLE: begin
          tcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (CntReady) begin
            StepsDone <= steps_nxt;
            if (last_req) begin
              state   <= S_FINISH;
              Done    <= 1'b1;
              Dec     <= 1'b0;
              Set     <= 1'b0;
              SetZero <= 1'b0;
              In      <= '0;
            end else begin
              state   <= S_ISSUE;
              Request <= 1'b1;
            end
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            state   <= S_FAULT;
            Err     <= 1'b1;
            Done    <= 1'b1;
            Dec     <= 1'b0;
            Set     <= 1'b0;
            SetZero <= 1'b0;
            In      <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_FINISH, S_FAULT: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dekatron_step_driver.sv
// Bench for dekatron_step_driver: BCD counter model with 5-cycle Ready, scoreboard of per-command results.
module tb_dekatron_step_driver;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Start = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic        Dir = 1'b0;
  logic [7:0]  Count = 8'd0;
  logic [11:0] LoadValue = 12'h000;
  logic        CntReady = 1'b0;
  logic        CntZero = 1'b1;
  logic        Request, Dec, Set, SetZero, Busy, Done, Err;
  logic [11:0] In;
  logic [7:0]  StepsDone;

  dekatron_step_driver #(.WIDTH(12), .CNT_WIDTH(8), .TIMEOUT(15)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Op(Op), .Dir(Dir), .Count(Count),
    .LoadValue(LoadValue), .CntReady(CntReady), .CntZero(CntZero), .Request(Request),
    .Dec(Dec), .Set(Set), .SetZero(SetZero), .In(In), .Busy(Busy), .Done(Done),
    .Err(Err), .StepsDone(StepsDone)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          steps;
    bit          err;
    int          reqs;
    logic [11:0] val;
  } exp_t;
  exp_t sb[$];

  // Counter model: three BCD digits, Ready pulses 5 cycles after Request.
  function automatic int bcd2int(input logic [11:0] b);
    return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [11:0] int2bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  function automatic logic [11:0] next_val(input logic [11:0] cur, input logic s, input logic z,
                                           input logic d, input logic [11:0] ld);
    if (z) return 12'h000;
    if (s) return ld;
    if (d) return int2bcd((bcd2int(cur) + 999) % 1000);
    return int2bcd((bcd2int(cur) + 1) % 1000);
  endfunction

  logic [11:0] cval = 12'h000;
  int          dly = 0;
  logic        p_dec = 1'b0, p_set = 1'b0, p_clr = 1'b0;
  logic [11:0] p_in = 12'h000;
  bit          ready_en = 1'b1;

  always @(posedge Clk) begin
    CntReady <= 1'b0;
    if (Request && ready_en) begin
      dly   <= 5;
      p_dec <= Dec;
      p_set <= Set;
      p_clr <= SetZero;
      p_in  <= In;
    end else if (dly > 0) begin
      dly <= dly - 1;
      if (dly == 1) begin
        cval     <= next_val(cval, p_set, p_clr, p_dec, p_in);
        CntZero  <= (next_val(cval, p_set, p_clr, p_dec, p_in) == 12'h000);
        CntReady <= 1'b1;
      end
    end
  end

  int req_cnt = 0, dec_reqs = 0, clr_reqs = 0, req_wide = 0, sel_conflict = 0, done_cnt = 0;
  bit prev_req = 1'b0;

  always @(negedge Clk) begin
    if (Request) begin
      req_cnt++;
      if (Dec) dec_reqs++;
      if (SetZero) clr_reqs++;
      if (prev_req) req_wide++;
    end
    if ((int'(Dec) + int'(Set) + int'(SetZero)) > 1) sel_conflict++;
    if (Done) done_cnt++;
    prev_req = Request;
  end

  int req_base = 0;

  task automatic drive_cmd(input logic [1:0] op, input logic dir, input int cnt, input logic [11:0] ld);
    @(negedge Clk);
    req_base  = req_cnt;
    Op        = op;
    Dir       = dir;
    Count     = 8'(cnt);
    LoadValue = ld;
    Start     = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic wait_done(output bit timed_out);
    timed_out = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (Done) return;
      @(negedge Clk);
    end
    timed_out = 1'b1;
  endtask

  task automatic test_reset;
    logic [26:0] got;
    Rst_n = 1'b0;
    Start = 1'b1;
    repeat (3) @(negedge Clk);
    got = {Request, Dec, Set, SetZero, In, Busy, Done, Err, StepsDone};
    n_checks++;
    if (got !== 27'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", got);
    end
    Start = 1'b0;
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);
    n_checks++;
    if (Busy !== 1'b0 || Request !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: Busy=%b Request=%b want 0 0", Busy, Request);
    end
  endtask

  task automatic test_step_inc;
    exp_t e;
    bit to;
    int d0, dec0;
    logic [28:0] got, want;
    d0 = done_cnt;
    dec0 = dec_reqs;
    sb.push_back('{steps: 3, err: 1'b0, reqs: 3, val: 12'h003});
    drive_cmd(2'b00, 1'b0, 3, 12'h000);
    wait_done(to);
    repeat (2) @(negedge Clk);
    e = sb.pop_front();
    got  = {StepsDone, Err, 8'(req_cnt - req_base), cval};
    want = {8'(e.steps), e.err, 8'(e.reqs), e.val};
    n_checks++;
    if (to || got !== want) begin
      n_fail++;
      $display("FAIL step_inc_result: got %h want %h timeout=%0d", got, want, to);
    end
    n_checks++;
    if (done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL step_inc_done_once: got %0d pulses want 1", done_cnt - d0);
    end
    n_checks++;
    if (dec_reqs != dec0) begin
      n_fail++;
      $display("FAIL step_inc_dec: got %0d Dec requests want 0", dec_reqs - dec0);
    end
    n_checks++;
    if (req_wide != 0) begin
      n_fail++;
      $display("FAIL step_inc_pulse_width: got %0d wide pulses want 0", req_wide);
    end
  endtask

  task automatic test_set;
    exp_t e;
    int bad = 0;
    int i = 0;
    logic [28:0] got, want;
    sb.push_back('{steps: 1, err: 1'b0, reqs: 1, val: 12'h357});
    drive_cmd(2'b01, 1'b0, 0, 12'h357);
    while (!Done && i < 600) begin
      if (Set !== 1'b1 || In !== 12'h357 || Dec !== 1'b0 || SetZero !== 1'b0) bad++;
      @(negedge Clk);
      i++;
    end
    n_checks++;
    if (bad != 0 || i >= 600) begin
      n_fail++;
      $display("FAIL set_selects_stable: got %0d bad cycles (loop %0d) want 0", bad, i);
    end
    repeat (2) @(negedge Clk);
    e = sb.pop_front();
    got  = {StepsDone, Err, 8'(req_cnt - req_base), cval};
    want = {8'(e.steps), e.err, 8'(e.reqs), e.val};
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL set_result: got %h want %h", got, want);
    end
  endtask

  task automatic test_dec_to_zero;
    exp_t e;
    bit to;
    int dec0;
    logic [28:0] got, want;
    sb.push_back('{steps: 1, err: 1'b0, reqs: 1, val: 12'h004});
    drive_cmd(2'b01, 1'b0, 0, 12'h004);
    wait_done(to);
    repeat (2) @(negedge Clk);
    e = sb.pop_front();
    got  = {StepsDone, Err, 8'(req_cnt - req_base), cval};
    want = {8'(e.steps), e.err, 8'(e.reqs), e.val};
    n_checks++;
    if (to || got !== want) begin
      n_fail++;
      $display("FAIL dtz_preload: got %h want %h timeout=%0d", got, want, to);
    end
    dec0 = dec_reqs;
    sb.push_back('{steps: 4, err: 1'b0, reqs: 4, val: 12'h000});
    drive_cmd(2'b11, 1'b0, 10, 12'h000);
    wait_done(to);
    repeat (2) @(negedge Clk);
    e = sb.pop_front();
    got  = {StepsDone, Err, 8'(req_cnt - req_base), cval};
    want = {8'(e.steps), e.err, 8'(e.reqs), e.val};
    n_checks++;
    if (to || got !== want) begin
      n_fail++;
      $display("FAIL dtz_result: got %h want %h timeout=%0d", got, want, to);
    end
    n_checks++;
    if (dec_reqs - dec0 != 4) begin
      n_fail++;
      $display("FAIL dtz_dec: got %0d Dec requests want 4", dec_reqs - dec0);
    end
  endtask

  task automatic test_zero_count;
    exp_t e;
    logic [28:0] got, want;
    sb.push_back('{steps: 0, err: 1'b0, reqs: 0, val: 12'h000});
    drive_cmd(2'b00, 1'b0, 0, 12'h000);
    n_checks++;
    if ({Done, Busy, Request} !== 3'b110) begin
      n_fail++;
      $display("FAIL zero_count_done: got Done/Busy/Request=%b want 110", {Done, Busy, Request});
    end
    @(negedge Clk);
    n_checks++;
    if ({Done, Busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL zero_count_idle: got Done/Busy=%b want 00", {Done, Busy});
    end
    @(negedge Clk);
    e = sb.pop_front();
    got  = {StepsDone, Err, 8'(req_cnt - req_base), cval};
    want = {8'(e.steps), e.err, 8'(e.reqs), e.val};
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL zero_count_result: got %h want %h", got, want);
    end
    sb.push_back('{steps: 0, err: 1'b0, reqs: 0, val: 12'h000});
    drive_cmd(2'b11, 1'b0, 5, 12'h000);
    n_checks++;
    if ({Done, Request} !== 2'b10) begin
      n_fail++;
      $display("FAIL dtz_at_zero_done: got Done/Request=%b want 10", {Done, Request});
    end
    repeat (2) @(negedge Clk);
    e = sb.pop_front();
    got  = {StepsDone, Err, 8'(req_cnt - req_base), cval};
    want = {8'(e.steps), e.err, 8'(e.reqs), e.val};
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL dtz_at_zero_result: got %h want %h", got, want);
    end
  endtask

  task automatic test_timeout;
    exp_t e;
    int n = 0;
    bit to;
    logic [28:0] got, want;
    ready_en = 1'b0;
    sb.push_back('{steps: 0, err: 1'b1, reqs: 1, val: 12'h000});
    drive_cmd(2'b00, 1'b0, 2, 12'h000);
    while (!Done && n < 100) begin
      @(negedge Clk);
      n++;
    end
    n_checks++;
    if (n != 17 || Err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_latency: got %0d cycles Err=%b want 17 cycles Err=1", n, Err);
    end
    repeat (2) @(negedge Clk);
    e = sb.pop_front();
    got  = {StepsDone, Err, 8'(req_cnt - req_base), cval};
    want = {8'(e.steps), e.err, 8'(e.reqs), e.val};
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL timeout_result: got %h want %h", got, want);
    end
    repeat (5) @(negedge Clk);
    n_checks++;
    if (Err !== 1'b1 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_err_sticky: got Err=%b Busy=%b want 1 0", Err, Busy);
    end
    ready_en = 1'b1;
    sb.push_back('{steps: 0, err: 1'b0, reqs: 0, val: 12'h000});
    drive_cmd(2'b00, 1'b0, 0, 12'h000);
    n_checks++;
    if (Err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_err_clear: got Err=%b want 0", Err);
    end
    wait_done(to);
    repeat (2) @(negedge Clk);
    e = sb.pop_front();
    got  = {StepsDone, Err, 8'(req_cnt - req_base), cval};
    want = {8'(e.steps), e.err, 8'(e.reqs), e.val};
    n_checks++;
    if (to || got !== want) begin
      n_fail++;
      $display("FAIL timeout_next_cmd: got %h want %h timeout=%0d", got, want, to);
    end
  endtask

  task automatic test_busy_start;
    exp_t e;
    bit to;
    int c0, d0;
    logic [28:0] got, want;
    c0 = clr_reqs;
    d0 = dec_reqs;
    sb.push_back('{steps: 2, err: 1'b0, reqs: 2, val: 12'h998});
    drive_cmd(2'b00, 1'b1, 2, 12'h000);
    Op    = 2'b10;
    Count = 8'd7;
    Start = 1'b1;
    repeat (3) @(negedge Clk);
    Start = 1'b0;
    wait_done(to);
    repeat (2) @(negedge Clk);
    e = sb.pop_front();
    got  = {StepsDone, Err, 8'(req_cnt - req_base), cval};
    want = {8'(e.steps), e.err, 8'(e.reqs), e.val};
    n_checks++;
    if (to || got !== want) begin
      n_fail++;
      $display("FAIL busy_start_result: got %h want %h timeout=%0d", got, want, to);
    end
    n_checks++;
    if (clr_reqs != c0 || dec_reqs - d0 != 2) begin
      n_fail++;
      $display("FAIL busy_start_selects: got clr=%0d dec=%0d want 0 2", clr_reqs - c0, dec_reqs - d0);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    bit to;
    logic [28:0] got, want;
    logic [1:0]  ops  [3] = '{2'b00, 2'b01, 2'b00};
    logic        dirs [3] = '{1'b0, 1'b0, 1'b1};
    int          cnts [3] = '{2, 0, 1};
    logic [11:0] lds  [3] = '{12'h000, 12'h123, 12'h000};
    sb.push_back('{steps: 2, err: 1'b0, reqs: 2, val: 12'h000});
    sb.push_back('{steps: 1, err: 1'b0, reqs: 1, val: 12'h123});
    sb.push_back('{steps: 1, err: 1'b0, reqs: 1, val: 12'h122});
    for (int k = 0; k < 3; k++) begin
      drive_cmd(ops[k], dirs[k], cnts[k], lds[k]);
      wait_done(to);
      e = sb.pop_front();
      got  = {StepsDone, Err, 8'(req_cnt - req_base), cval};
      want = {8'(e.steps), e.err, 8'(e.reqs), e.val};
      n_checks++;
      if (to || got !== want) begin
        n_fail++;
        $display("FAIL back_to_back_%0d: got %h want %h timeout=%0d", k, got, want, to);
      end
    end
  endtask

  task automatic test_reset_mid;
    int n = 0;
    int d0;
    logic [26:0] got;
    drive_cmd(2'b00, 1'b0, 5, 12'h000);
    for (int i = 0; i < 100; i++) begin
      if (Request) n++;
      if (n == 2) break;
      @(negedge Clk);
    end
    repeat (3) @(negedge Clk);
    d0 = done_cnt;
    Rst_n = 1'b0;
    @(negedge Clk);
    got = {Request, Dec, Set, SetZero, In, Busy, Done, Err, StepsDone};
    n_checks++;
    if (n != 2 || got !== 27'h0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got %h (reqs seen %0d) want 0 (2)", got, n);
    end
    Rst_n = 1'b1;
    repeat (12) @(negedge Clk);
    n_checks++;
    if (done_cnt != d0 || Busy !== 1'b0 || Request !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_no_done: got %0d Done pulses Busy=%b want 0 0", done_cnt - d0, Busy);
    end
  endtask

  initial begin
    test_reset();
    test_step_inc();
    test_set();
    test_dec_to_zero();
    test_zero_count();
    test_timeout();
    test_busy_start();
    test_back_to_back();
    test_reset_mid();
    n_checks++;
    if (sel_conflict != 0 || req_wide != 0) begin
      n_fail++;
      $display("FAIL global_selects: got conflicts=%0d wide=%0d want 0 0", sel_conflict, req_wide);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
